interval_timer: RTL
===================

Name: interval_timer

Overview:
- Memory-mapped programmable interval timer on the processor bus, at base 0x2000, the free slot between the LED register (0x1xxx) and the switch port (0x3xxx).
- Consumes the processor's ADDR, DOUT and W. Returns read data for the top-level DIN mux with the same one-cycle registered latency as the instruction memory.
- Provides a sticky expiry flag so programs can poll for fixed time intervals.

Parameters:
- PRESCALE, 50000: Clock cycles per timer tick (1 ms at 50 MHz). Must be ≥ 1.
- BASE, 4'h2: Value of ADDR[15:12] that selects this block.

Ports:
- Clock  input  1  System clock, rising edge.
- Reset  input  1  Synchronous, active-high reset.
- ADDR  input  16  Processor address.
- DOUT  input  16  Processor write data.
- W  input  1  Processor write strobe.
- Q  output  16  Registered read data, valid one cycle after the address is presented.
- Done  output  1  Sticky expiry flag (the STATUS[0] bit).

Behaviour:
- Select: cs = (ADDR[15:12] == BASE). A write occurs when cs & W. The register is chosen by ADDR[1:0]; ADDR[11:2] are ignored, so the registers alias across the 4K window.
- Register map:
  - 0 LOAD: R/W, 16 bits.
  - 1 COUNT: read-only; writes are ignored.
  - 2 CTRL: R/W. [0] EN, [1] AUTO (auto-reload). Other bits read 0.
  - 3 STATUS: [0] DONE. Writing with DOUT[0]=1 clears DONE; writing DOUT[0]=0 has no effect. Other bits read 0.
- Reset: LOAD, COUNT, CTRL, DONE, prescaler and Q all go to 0. Done=0.
- Read path: Q is updated every clock edge.
  - When cs: Q <= the selected register's value as it was before that edge.
  - When not cs: Q <= 0.
- Prescaler:
  - Counts 0..PRESCALE-1 only while EN=1.
  - A tick is asserted in the cycle where prescaler == PRESCALE-1; the prescaler then wraps to 0.
  - Prescaler width = clog2(PRESCALE), with a minimum of 1.
- State is implied by {EN, DONE}:
  - IDLE: EN=0.
  - RUN: EN=1.
  - EXPIRED: DONE=1; can coexist with RUN when AUTO=1.
- Start: a CTRL write whose DOUT[0]=1 while EN is currently 0 does three things:
  - COUNT <= LOAD;
  - prescaler <= 0;
  - EN <= 1.
  Writing EN=1 while already running only updates AUTO; it does not restart the count.
- Stop: a CTRL write with DOUT[0]=0 clears EN. COUNT and the prescaler hold their values. A later start reloads from LOAD.
- On a tick with EN=1:
  - COUNT > 1: COUNT <= COUNT-1.
  - COUNT ≤ 1: expire. DONE <= 1, then:
    - AUTO=1: COUNT <= LOAD and EN stays 1.
    - AUTO=0: COUNT <= 0 and EN <= 0.
- Period: LOAD ticks, with LOAD=0 treated as a period of 1 tick.
- LOAD writes while running take effect only at the next reload or start.
- Simultaneous events:
  - Expiry and a DONE-clear in the same cycle: set wins, DONE=1.
  - Tick and a CTRL stop write in the same cycle: the write wins, EN=0, and the tick is discarded (COUNT does not change).
  - Tick and a CTRL start write: impossible, because no tick occurs while EN=0.
- Reset mid-count: all state returns to reset values on the next edge. No expiry is generated.
- COUNT never wraps below 0.
- Done output = DONE register (no extra latency).

Test Plan:
- Reset and read-back (PRESCALE=4):
  - Assert Reset 2 cycles, then read all 4 registers → Q=0 each, one cycle after the address; Done=0.
  - Write LOAD=0x0003 and read → Q=0x0003.
  - Read at 0x1000 → Q=0.
- One-shot:
  - LOAD=3, then CTRL=0x0001.
  - COUNT reads 3, 2, 1 at 4-cycle intervals.
  - Done rises exactly 12 cycles after the start write; COUNT=0 and CTRL reads 0x0000.
- Auto-reload:
  - LOAD=2, CTRL=0x0003 → Done=1 after 8 cycles; COUNT=2 and EN remains 1.
  - Write STATUS=1 → Done=0.
  - Done returns 8 cycles after the previous expiry.
- Clear/set collision: issue a STATUS=1 write in the exact expiry cycle → Done=1 afterwards.
- Stop/restart:
  - Stop with CTRL=0 when COUNT=2 → COUNT holds at 2 for 20 cycles.
  - Write LOAD=5, then CTRL=1 → COUNT=5; expiry occurs 20 cycles after the restart.
- Re-enable and reset while running:
  - Write CTRL=1 again while running → no restart; the expiry time is unchanged.
  - Assert Reset while COUNT=2 → all registers 0; Done stays 0 for 50 cycles.

Source files
------------

// File: rtl/interval_timer_if.sv
// ============================================================================
// Module      : interval_timer_if
// Description : Processor bus bundle that connects the CPU to the interval
//               timer: address, write data and write strobe go out; the
//               registered read data and the sticky expiry flag come back.
//   addr [15:0] processor address
//   dout [15:0] processor write data
//   w           processor write strobe
//   q    [15:0] registered read data (one cycle after the address)
//   done        sticky expiry flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface interval_timer_if;
  logic [15:0] addr;
  logic [15:0] dout;
  logic        w;
  logic [15:0] q;
  logic        done;

  // The processor side drives the bus and reads back data and the flag.
  modport master (
    output addr,
    output dout,
    output w,
    input  q,
    input  done
  );

  // The timer side decodes the bus and returns data and the flag.
  modport slave (
    input  addr,
    input  dout,
    input  w,
    output q,
    output done
  );
endinterface

`default_nettype wire

// File: rtl/interval_timer.sv
// ============================================================================
// Module      : interval_timer
// Description : Memory-mapped programmable interval timer. A prescaler divides
//               clk into ticks; COUNT decrements once per tick and, on
//               reaching the end of the period, sets a sticky DONE flag and
//               either reloads (AUTO) or stops.
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   bus (slave)  addr/dout/w in, q (registered read data) and done out
//   Register map (addr[1:0]): 0 LOAD, 1 COUNT (RO), 2 CTRL {AUTO,EN},
//                             3 STATUS {DONE}, write 1 to clear
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module interval_timer #(
  parameter int         PRESCALE = 50000,
  parameter logic [3:0] BASE     = 4'h2
) (
  input wire logic          clk,
  input wire logic          rst,
  interval_timer_if.slave   bus
);

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

  localparam logic [1:0] REG_LOAD   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [15:0]        load_q,  load_d;
  logic [15:0]        count_q, count_d;
  logic               en_q,    en_d;
  logic               auto_q,  auto_d;
  logic               done_q,  done_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [15:0]        q_q,     q_d;

  logic        cs;
  logic        wr;
  logic [1:0]  sel;
  logic        tick;
  logic        expire;
  logic        done_clr;
  logic        unused_addr_bits;

  // Address bits 11:2 do not take part in decoding; the registers alias
  // across the whole 4K window.
  assign unused_addr_bits = ^bus.addr[11:2];

  assign cs   = (bus.addr[15:12] == BASE);
  assign wr   = cs & bus.w;
  assign sel  = bus.addr[1:0];
  assign tick = en_q & (presc_q == PRESC_MAX);

  always_comb begin
    load_d   = load_q;
    count_d  = count_q;
    en_d     = en_q;
    auto_d   = auto_q;
    done_d   = done_q;
    presc_d  = presc_q;
    q_d      = 16'h0000;
    expire   = 1'b0;
    done_clr = 1'b0;

    // Prescaler and countdown, only while enabled.
    if (en_q) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (count_q > 16'd1) begin
          count_d = count_q - 16'd1;
        end else begin
          // COUNT of 0 or 1 ends the period, so LOAD=0 behaves like LOAD=1.
          expire = 1'b1;
          if (auto_q) begin
            count_d = load_q;
          end else begin
            count_d = 16'h0000;
            en_d    = 1'b0;
          end
        end
      end
    end

    if (wr) begin
      case (sel)
        REG_LOAD: load_d = bus.dout;
        REG_CTRL: begin
          auto_d = bus.dout[1];
          if (bus.dout[0]) begin
            // Enabling while already running only updates AUTO.
            if (!en_q) begin
              count_d = load_q;
              presc_d = '0;
              en_d    = 1'b1;
            end
          end else begin
            // A stop write overrides a coincident tick: the tick is
            // discarded and COUNT/prescaler freeze where they were.
            en_d    = 1'b0;
            count_d = count_q;
            presc_d = presc_q;
            expire  = 1'b0;
          end
        end
        REG_STATUS: done_clr = bus.dout[0];
        default: ;
      endcase
    end

    // Expiry beats a coincident clear.
    if (expire) begin
      done_d = 1'b1;
    end else if (done_clr) begin
      done_d = 1'b0;
    end

    // Read data reflects register state before this edge.
    if (cs) begin
      case (sel)
        REG_LOAD:   q_d = load_q;
        REG_COUNT:  q_d = count_q;
        REG_CTRL:   q_d = {14'h0000, auto_q, en_q};
        REG_STATUS: q_d = {15'h0000, done_q};
        default:    q_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_q  <= 16'h0000;
      count_q <= 16'h0000;
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      done_q  <= 1'b0;
      presc_q <= '0;
      q_q     <= 16'h0000;
    end else begin
      load_q  <= load_d;
      count_q <= count_d;
      en_q    <= en_d;
      auto_q  <= auto_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      q_q     <= q_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.done = done_q;

endmodule

`default_nettype wire
